// File: rtl/glb_stream_sink.sv
// glb_stream_sink: captures NUM_BLOCKS length-prefixed blocks into per-block storage with registered readback.
// Optional GLB_SINK_THROTTLE_EN adds LFSR-driven pseudo-random ready stalls.
module glb_stream_sink #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int NUM_BLOCKS = 2,
    parameter logic [15:0] THROTTLE_SEED = 16'hACE1,
    localparam int BW = NUM_BLOCKS > 1 ? $clog2(NUM_BLOCKS) : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic [DATA_WIDTH-1:0]            data,
    input  logic                             valid,
    output logic                             ready,
    output logic                             done,
    output logic                             overflow,
    output logic [NUM_BLOCKS*DATA_WIDTH-1:0] blk_len,
    input  logic [BW-1:0]                    rd_block,
    input  logic [AW-1:0]                    rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data
);
    typedef enum logic [1:0] {S_HDR, S_DATA, S_DONE} state_t;

    localparam logic [BW-1:0]     LAST_BLK = BW'(NUM_BLOCKS - 1);
    localparam logic [BW:0]       NB       = (BW + 1)'(NUM_BLOCKS);
    localparam logic [DATA_WIDTH:0] DEP    = (DATA_WIDTH + 1)'(DEPTH);

    state_t                  state, state_n;
    logic [BW-1:0]           blk_idx;
    logic [DATA_WIDTH:0]     cnt;
    logic [DATA_WIDTH-1:0]   cur_len;
    logic                    rdy, thr, xfer, hdr_x, dat_x, blk_done, last_blk;
    logic [DATA_WIDTH-1:0]   mem [NUM_BLOCKS][DEPTH];

    // clear must block the handshake in its own cycle, so it gates the registered ready
    assign ready = rdy & ~clear;
    assign xfer  = ready & valid;

`ifdef GLB_SINK_THROTTLE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     lfsr <= THROTTLE_SEED;
        else if (clear) lfsr <= THROTTLE_SEED;
        else            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign thr = lfsr[1:0] != 2'b00;
`else
    assign thr = 1'b1;
`endif

    always_comb begin
        hdr_x    = xfer && state == S_HDR;
        dat_x    = xfer && state == S_DATA;
        last_blk = blk_idx == LAST_BLK;
        blk_done = (hdr_x && data == '0) || (dat_x && cnt + 1'b1 == {1'b0, cur_len});
        state_n  = clear ? S_HDR :
                   blk_done ? (last_blk ? S_DONE : S_HDR) :
                   hdr_x ? S_DATA : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HDR;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy      <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            blk_len  <= '0;
            blk_idx  <= '0;
            cnt      <= '0;
            cur_len  <= '0;
        end else if (clear) begin
            rdy      <= 1'b1;
            done     <= 1'b0;
            overflow <= 1'b0;
            blk_len  <= '0;
            blk_idx  <= '0;
            cnt      <= '0;
            cur_len  <= '0;
        end else begin
            if (hdr_x) begin
                blk_len[blk_idx*DATA_WIDTH +: DATA_WIDTH] <= data;
                cur_len <= data;
                cnt     <= '0;
                if ({1'b0, data} > DEP) overflow <= 1'b1;
            end
            if (dat_x) cnt <= cnt + 1'b1;
            if (blk_done && !last_blk) blk_idx <= blk_idx + 1'b1;
            done <= state_n == S_DONE;
            rdy  <= state_n != S_DONE && thr;
        end
    end

    // storage is deliberately left unreset so partial captures survive reset/clear
    always_ff @(posedge clk) begin
        if (dat_x && cnt < DEP) mem[blk_idx][cnt[AW-1:0]] <= data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= {1'b0, rd_block} < NB ? mem[rd_block][rd_addr] : '0;
    end
endmodule
